// File: rtl/rx_ctrl_pkg.sv
// rx_ctrl_pkg: shared definitions for the serial frame receiver.
//   rx_state_t     bit-level receive FSM state encoding
//   START_BIT_LVL  line level of a valid start bit
//   STOP_BIT_LVL   line level of a valid stop bit
package rx_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_START    = 3'd1,
      ST_DATA     = 3'd2,
      ST_WAIT_DES = 3'd3,
      ST_STOP     = 3'd4
   } rx_state_t;

   localparam logic START_BIT_LVL = 1'b0;
   localparam logic STOP_BIT_LVL  = 1'b1;

endpackage

// File: rtl/rx_byte_fifo.sv
// rx_byte_fifo: small synchronous FIFO holding payload bytes with sof/last tags.
//   clk, rst_n                   clock, async active-low reset (empties FIFO)
//   push, push_data/sof/last     write request and entry contents
//   pop                          read request (ignored when empty)
//   rd_data/sof/last             head entry, forced to zero when empty
//   full, empty                  occupancy status
//   drop                         push refused because FIFO is full and not popping
module rx_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             push_sof,
   input  logic             push_last,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_sof,
   output logic             rd_last,
   output logic             full,
   output logic             empty,
   output logic             drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH+1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             rd_ok;
   logic             wr_ok;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_ok = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_ok = push && (!full || rd_ok);
   assign drop  = push && !wr_ok;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= {push_sof, push_last, push_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Memory is not reset; gating keeps outputs at zero while empty.
   always_comb begin
      rd_data = '0;
      rd_sof  = 1'b0;
      rd_last = 1'b0;
      if (!empty) begin
         {rd_sof, rd_last, rd_data} = mem[rd_ptr];
      end
   end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: UART-style frame receiver controller.
// Drives an external deserializer with bit-centre strobes, checks start/stop
// framing, interprets the first byte of each frame as a payload length and
// streams the payload through a small tagged FIFO.
//   clk, rst_n             clock, async active-low reset
//   serial_in              serial line, idle high
//   des_start, des_enable  deserializer control (first-bit marker, sample strobe)
//   des_data, des_valid    deserializer parallel byte and completion strobe
//   out_data/valid/ready   payload stream, out_sof/out_last frame markers
//   err_frame/len/ovf      sticky error flags, cleared by err_clr
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | line idle, waiting for a falling edge
// START      | timing to start-bit centre, rejects short glitches
// DATA       | issuing one des_enable per bit at bit centre
// WAIT_DES   | waiting (2 cycles max) for the deserializer byte
// STOP       | timing to stop-bit centre, accept or abort the byte
module rx_frame_ctrl
   import rx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int MAX_LEN      = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  serial_in,
   output logic                  des_start,
   output logic                  des_enable,
   input  logic [DATA_WIDTH-1:0] des_data,
   input  logic                  des_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_sof,
   output logic                  out_last,
   output logic                  err_frame,
   output logic                  err_len,
   output logic                  err_ovf,
   input  logic                  err_clr
);

   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int NW = $clog2(DATA_WIDTH + 1);
   localparam int CW = $clog2(MAX_LEN + 1);

   localparam logic [BW-1:0]         HALF_TC   = BW'(CLKS_PER_BIT/2 - 1);
   localparam logic [BW-1:0]         BIT_TC    = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0]         WAIT_TC   = BW'(CLKS_PER_BIT - 2);
   localparam logic [NW-1:0]         NBITS     = NW'(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] MAX_LEN_B = DATA_WIDTH'(MAX_LEN);
   localparam logic [CW-1:0]         MAX_CNT   = CW'(MAX_LEN);

   rx_state_t             state, state_nxt;
   logic [BW-1:0]         baud_cnt, baud_nxt;
   logic [NW-1:0]         bit_cnt, bit_nxt;
   logic [DATA_WIDTH-1:0] byte_reg;
   logic                  capture;
   logic                  byte_ok;
   logic                  frame_err;

   logic [DATA_WIDTH-1:0] rem;
   logic [CW-1:0]         byte_cnt;
   logic                  len_drop;
   logic                  len_err;
   logic                  push;
   logic                  fifo_drop;
   logic                  fifo_full;
   logic                  fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
      end
   end

   // The baud timer free-runs downward through WAIT_DES into STOP, so the
   // stop-bit centre is exactly one bit period after the last data strobe.
   always_comb begin
      state_nxt  = state;
      baud_nxt   = baud_cnt - 1'b1;
      bit_nxt    = bit_cnt;
      des_enable = 1'b0;
      des_start  = 1'b0;
      capture    = 1'b0;
      byte_ok    = 1'b0;
      frame_err  = 1'b0;
      case (state)
         ST_IDLE: begin
            baud_nxt = HALF_TC;
            if (serial_in == START_BIT_LVL) state_nxt = ST_START;
         end
         ST_START: begin
            if (baud_cnt == '0) begin
               if (serial_in == START_BIT_LVL) begin
                  state_nxt = ST_DATA;
                  baud_nxt  = BIT_TC;
                  bit_nxt   = NBITS;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_DATA: begin
            if (baud_cnt == '0) begin
               des_enable = 1'b1;
               des_start  = (bit_cnt == NBITS);
               bit_nxt    = bit_cnt - 1'b1;
               baud_nxt   = BIT_TC;
               if (bit_cnt == NW'(1)) state_nxt = ST_WAIT_DES;
            end
         end
         ST_WAIT_DES: begin
            if (des_valid) begin
               capture   = 1'b1;
               state_nxt = ST_STOP;
            end else if (baud_cnt == WAIT_TC) begin
               frame_err = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_STOP: begin
            if (baud_cnt == '0) begin
               if (serial_in == STOP_BIT_LVL) byte_ok = 1'b1;
               else                           frame_err = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       byte_reg <= '0;
      else if (capture) byte_reg <= des_data;
   end

   // rem counts payload bytes still owed by the current frame; zero means the
   // next accepted byte is a length byte.
   assign len_err = byte_ok && (rem == '0) && (byte_reg > MAX_LEN_B);
   assign push    = byte_ok && (rem != '0) && !len_drop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= '0;
         byte_cnt <= '0;
         len_drop <= 1'b0;
      end else if (frame_err) begin
         rem      <= '0;
         byte_cnt <= '0;
         len_drop <= 1'b0;
      end else if (byte_ok) begin
         if (rem == '0) begin
            rem      <= byte_reg;
            byte_cnt <= '0;
            len_drop <= len_err;
         end else begin
            rem <= rem - 1'b1;
            if (byte_cnt != MAX_CNT) byte_cnt <= byte_cnt + 1'b1;
         end
      end
   end

   // A new error takes priority over a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_frame <= 1'b0;
         err_len   <= 1'b0;
         err_ovf   <= 1'b0;
      end else begin
         err_frame <= frame_err | (err_frame & ~err_clr);
         err_len   <= len_err   | (err_len   & ~err_clr);
         err_ovf   <= fifo_drop | (err_ovf   & ~err_clr);
      end
   end

   rx_byte_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (byte_reg),
      .push_sof  (byte_cnt == '0),
      .push_last (rem == DATA_WIDTH'(1)),
      .pop       (out_ready),
      .rd_data   (out_data),
      .rd_sof    (out_sof),
      .rd_last   (out_last),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .drop      (fifo_drop)
   );

   assign out_valid = !fifo_empty;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl: randomized and directed stimulus for rx_frame_ctrl with a
// behavioural deserializer and a frame-level expected-output queue.
module tb_rx_frame_ctrl;

   localparam int DW  = 8;
   localparam int CPB = 4;
   localparam int ML  = 16;
   localparam int FD  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          serial_in;
   logic          des_start;
   logic          des_enable;
   logic [DW-1:0] des_data;
   logic          des_valid;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          out_sof;
   logic          out_last;
   logic          err_frame;
   logic          err_len;
   logic          err_ovf;
   logic          err_clr;

   rx_frame_ctrl #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB),
      .MAX_LEN      (ML),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .serial_in  (serial_in),
      .des_start  (des_start),
      .des_enable (des_enable),
      .des_data   (des_data),
      .des_valid  (des_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sof    (out_sof),
      .out_last   (out_last),
      .err_frame  (err_frame),
      .err_len    (err_len),
      .err_ovf    (err_ovf),
      .err_clr    (err_clr)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [DW+1:0] exp_q[$];
   logic          exp_frame = 1'b0;
   logic          exp_len   = 1'b0;
   logic          exp_ovf   = 1'b0;
   int            keep_max  = 1000;
   logic [DW-1:0] pay [32];
   int            n_sent = 0;
   int            n_des_start = 0;
   logic          rdy_rand = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Deserializer model: shifts the line on each strobe, first bit ends in MSB.
   logic [DW-1:0] ds_sh;
   int            ds_n;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         des_valid <= 1'b0;
         des_data  <= '0;
         ds_sh     <= '0;
         ds_n      <= 0;
      end else begin
         des_valid <= 1'b0;
         if (des_enable) begin
            ds_sh <= {ds_sh[DW-2:0], serial_in};
            ds_n  <= des_start ? 1 : ds_n + 1;
            if ((des_start ? 1 : ds_n + 1) == DW) begin
               des_valid <= 1'b1;
               des_data  <= {ds_sh[DW-2:0], serial_in};
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && des_start) n_des_start++;
   end

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) check_val("out_extra", 32'(exp_q.size()), 32'd1);
         else                   check_val("out_beat", {out_sof, out_last, out_data}, exp_q.pop_front());
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic line(input logic v, input int n);
      serial_in = v;
      if (n > 0) begin
         repeat (n) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [DW-1:0] b, input bit bad_stop);
      n_sent++;
      line(1'b0, CPB);
      for (int j = DW-1; j >= 0; j--) line(b[j], CPB);
      line(bad_stop ? 1'b0 : 1'b1, CPB);
      line(1'b1, bad_stop ? 2*CPB : int'($urandom_range(0, 3)));
   endtask

   // Frame-level model: length byte, then payload; expected beats are queued
   // before each byte goes out so the monitor never races the DUT.
   task automatic send_frame(input int len, input int bad_at);
      send_byte(DW'(len), 1'b0);
      if (len > ML) exp_len = 1'b1;
      for (int i = 1; i <= len; i++) begin
         if (i == bad_at) begin
            exp_frame = 1'b1;
            send_byte(pay[i-1], 1'b1);
            return;
         end
         if (len <= ML && i <= keep_max) exp_q.push_back({i == 1, i == len, pay[i-1]});
         send_byte(pay[i-1], 1'b0);
      end
   endtask

   task automatic wait_drain(input string tag);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 4000) begin
         @(posedge clk);
         #1;
         t++;
      end
      check_val(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_errs(input string tag);
      check_val(tag, {err_frame, err_len, err_ovf}, {exp_frame, exp_len, exp_ovf});
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr   = 1'b0;
      exp_frame = 1'b0;
      exp_len   = 1'b0;
      exp_ovf   = 1'b0;
      check_val({tag, "_clr"}, {err_frame, err_len, err_ovf}, 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int sent0;
      rst_n     = 1'b0;
      serial_in = 1'b1;
      err_clr   = 1'b0;
      out_ready = 1'b0;
      #1;
      check_val("rst_outs", {des_start, des_enable, out_valid, out_sof, out_last,
                             err_frame, err_len, err_ovf}, 32'd0);
      check_val("rst_data", 32'(out_data), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      line(1'b1, 3);

      // Basic three-byte frame.
      out_ready = 1'b1;
      pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF;
      send_frame(3, 0);
      wait_drain("basic_drain");
      check_errs("basic_errs");

      // One-cycle low glitch on an idle line.
      sent0 = n_des_start;
      line(1'b0, 1);
      line(1'b1, 12);
      check_val("glitch_des_start", 32'(n_des_start), 32'(sent0));
      check_val("glitch_flags", {out_valid, err_frame, err_len, err_ovf}, 32'd0);

      // Bad stop bit on payload byte 2, then a normal frame.
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
      send_frame(4, 2);
      pay[0] = 8'h55;
      send_frame(1, 0);
      wait_drain("stop_err_drain");
      check_errs("stop_err_errs");

      // Oversized length; a clear held across the error must not mask it.
      for (int i = 0; i < 20; i++) pay[i] = DW'($urandom);
      err_clr = 1'b1;
      fork
         send_frame(20, 0);
         begin
            for (int t = 0; t < 200; t++) begin
               @(negedge clk);
               if (err_len) break;
            end
            err_clr = 1'b0;
         end
      join
      err_clr = 1'b0;
      check_val("len_set_vs_clr", 32'(err_len), 32'd1);
      pay[0] = 8'h0F;
      send_frame(1, 0);
      wait_drain("len_drain");
      check_errs("len_errs");

      // Overflow: ready held low, only the first FD bytes survive.
      out_ready = 1'b0;
      keep_max  = FD;
      for (int i = 0; i < 6; i++) pay[i] = DW'(8'h60 + i);
      send_frame(6, 0);
      exp_ovf = 1'b1;
      check_val("ovf_flag", {out_valid, err_ovf}, 32'd3);
      out_ready = 1'b1;
      wait_drain("ovf_drain");
      keep_max = 1000;

      // Reset in the middle of a byte with a byte pending and err_ovf set.
      out_ready = 1'b0;
      pay[0] = 8'hAA;
      send_frame(1, 0);
      check_val("latency_valid", {out_valid, out_data}, {1'b1, 8'hAA});
      send_byte(8'd2, 1'b0);
      n_sent++;
      line(1'b0, CPB);
      line(1'b1, CPB);
      line(1'b0, CPB);
      line(1'b1, 2);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      exp_frame = 1'b0; exp_len = 1'b0; exp_ovf = 1'b0;
      check_val("midrst_outs", {des_start, des_enable, out_valid, out_sof, out_last,
                                err_frame, err_len, err_ovf}, 32'd0);
      check_val("midrst_data", 32'(out_data), 32'd0);
      serial_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      line(1'b1, 2*CPB);
      out_ready = 1'b1;
      pay[0] = 8'h12; pay[1] = 8'h34;
      send_frame(2, 0);
      wait_drain("post_rst_drain");
      check_errs("post_rst_errs");

      // Random frames with random back-pressure.
      rdy_rand = 1'b1;
      for (int f = 0; f < 25; f++) begin
         int len;
         int bad;
         len = int'($urandom_range(0, ML + 4));
         for (int i = 0; i < len; i++) pay[i] = DW'($urandom);
         bad = (len > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, len)) : 0;
         send_frame(len, bad);
      end
      wait_drain("rand_drain");
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
      check_errs("rand_errs");
      check_val("des_start_count", 32'(n_des_start), 32'(n_sent));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
